// File: rtl/libnet_pkg.sv
// libnet_pkg: shared header-field layout, AXIS widths, tracker FSM states and sequence classifier.
package libnet_pkg;
  localparam int SEQ_W = 32;
  localparam int SEQ_LSB = 0;
  localparam int APP_BIT = 32;
  localparam int DATA_W = 512;
  localparam int KEEP_W = 64;
  localparam logic [SEQ_W-1:0] SEQ_RESET = 32'h1;
  typedef enum logic [1:0] {HDR, PASS, DROP} state_t;
  typedef enum logic [1:0] {IN_ORDER, DUP, AHEAD} cls_t;
  // Serial-number compare: anything up to half the space behind expected is a retransmit.
  function automatic cls_t classify(input logic [SEQ_W-1:0] expected, input logic [SEQ_W-1:0] seq);
    logic [SEQ_W-1:0] d;
    d = expected - seq;
    return d == '0 ? IN_ORDER : (d <= 32'h8000_0000 ? DUP : AHEAD);
  endfunction
endpackage

// File: rtl/ack_seq_slot.sv
// ack_seq_slot: per-app expected/last-accepted sequence registers and header classification.
module ack_seq_slot
  import libnet_pkg::*;
#(
  parameter logic [SEQ_W-1:0] SEQ_INIT = SEQ_RESET
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [SEQ_W-1:0] seq,
  input  logic             upd,
  output cls_t             cls,
  output logic [SEQ_W-1:0] seq_out,
  output logic             seq_valid
);
  logic [SEQ_W-1:0] expected;
  always_comb cls = classify(expected, seq);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      expected <= SEQ_INIT;
      seq_out <= '0;
      seq_valid <= 1'b0;
    end else if (upd) begin
      expected <= seq + 1;
      seq_out <= seq;
      seq_valid <= 1'b1;
    end
endmodule

// File: rtl/ack_seq_tracker.sv
// ack_seq_tracker: forwards in-order packets per app, drops duplicates/ahead packets, reports last accepted seq.
// Optional drop counter enabled by ACK_SEQ_TRACKER_STATS_EN.
module ack_seq_tracker
  import libnet_pkg::*;
#(
  parameter logic [SEQ_W-1:0] SEQ_INIT = SEQ_RESET
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] s_tdata,
  input  logic [KEEP_W-1:0] s_tkeep,
  input  logic [63:0]       s_tuser,
  input  logic              s_tvalid,
  input  logic              s_tlast,
  output logic              s_tready,
  output logic [DATA_W-1:0] m_tdata,
  output logic [KEEP_W-1:0] m_tkeep,
  output logic [63:0]       m_tuser,
  output logic              m_tvalid,
  output logic              m_tlast,
  input  logic              m_tready,
  output logic [SEQ_W-1:0]  seq0_out,
  output logic              seq0_valid,
  output logic [SEQ_W-1:0]  seq1_out,
  output logic              seq1_valid
`ifdef ACK_SEQ_TRACKER_STATS_EN
  ,
  output logic [31:0]       drop_cnt
`endif
);
  state_t state;
  cls_t cls0, cls1, cls;
  logic [SEQ_W-1:0] seq;
  logic app, hdr, fwd, hs, take;
  assign seq = s_tdata[SEQ_LSB +: SEQ_W];
  assign app = s_tdata[APP_BIT];
  assign cls = app ? cls1 : cls0;
  assign hdr = state == HDR;
  assign fwd = state == PASS || (hdr && cls == IN_ORDER);
  // Reset gates the handshake combinationally so it takes effect without waiting for a clock.
  assign s_tready = !reset && (fwd ? m_tready : 1'b1);
  assign m_tvalid = !reset && s_tvalid && fwd;
  assign hs = s_tvalid && s_tready;
  assign take = hdr && hs && cls == IN_ORDER;
  assign m_tdata = s_tdata;
  assign m_tkeep = s_tkeep;
  assign m_tuser = s_tuser;
  assign m_tlast = s_tlast;
  ack_seq_slot #(.SEQ_INIT(SEQ_INIT)) u_slot0 (
    .clk(clk), .reset(reset), .seq(seq), .upd(take && !app),
    .cls(cls0), .seq_out(seq0_out), .seq_valid(seq0_valid)
  );
  ack_seq_slot #(.SEQ_INIT(SEQ_INIT)) u_slot1 (
    .clk(clk), .reset(reset), .seq(seq), .upd(take && app),
    .cls(cls1), .seq_out(seq1_out), .seq_valid(seq1_valid)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= HDR;
    else if (hs) state <= s_tlast ? HDR : (hdr ? (cls == IN_ORDER ? PASS : DROP) : state);
`ifdef ACK_SEQ_TRACKER_STATS_EN
  always_ff @(posedge clk or posedge reset)
    if (reset) drop_cnt <= '0;
    else if (hdr && hs && cls == AHEAD && drop_cnt != '1) drop_cnt <= drop_cnt + 1;
`endif
endmodule

// File: tb/tb_ack_seq_tracker.sv
// tb_ack_seq_tracker: scoreboard bench with randomized packets against a per-app sequence model.
module tb_ack_seq_tracker;
  logic clk = 0, reset = 1;
  always #5 clk = ~clk;
  logic [511:0] s_tdata = '0, m_tdata, w_tdata;
  logic [63:0] s_tkeep = '0, s_tuser = '0, m_tkeep, m_tuser, w_tkeep, w_tuser;
  logic s_tvalid = 0, s_tlast = 0, s_tready, m_tvalid, m_tlast, m_tready = 1;
  logic w_tready, w_m_tvalid, w_tlast;
  logic [31:0] seq0_out, seq1_out, w_seq0_out, w_seq1_out;
  logic seq0_valid, seq1_valid, w_seq0_valid, w_seq1_valid;
`ifdef ACK_SEQ_TRACKER_STATS_EN
  logic [31:0] drop_cnt, w_drop_cnt;
`endif
  ack_seq_tracker dut (
    .clk(clk), .reset(reset), .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tuser(s_tuser),
    .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready), .m_tdata(m_tdata),
    .m_tkeep(m_tkeep), .m_tuser(m_tuser), .m_tvalid(m_tvalid), .m_tlast(m_tlast),
    .m_tready(m_tready), .seq0_out(seq0_out), .seq0_valid(seq0_valid),
    .seq1_out(seq1_out), .seq1_valid(seq1_valid)
`ifdef ACK_SEQ_TRACKER_STATS_EN
    , .drop_cnt(drop_cnt)
`endif
  );
  // Second instance starts with expected = 32'hFFFFFFFF so sequence wrap can be reached directly.
  ack_seq_tracker #(.SEQ_INIT(32'hFFFF_FFFF)) dut_w (
    .clk(clk), .reset(reset), .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tuser(s_tuser),
    .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(w_tready), .m_tdata(w_tdata),
    .m_tkeep(w_tkeep), .m_tuser(w_tuser), .m_tvalid(w_m_tvalid), .m_tlast(w_tlast),
    .m_tready(m_tready), .seq0_out(w_seq0_out), .seq0_valid(w_seq0_valid),
    .seq1_out(w_seq1_out), .seq1_valid(w_seq1_valid)
`ifdef ACK_SEQ_TRACKER_STATS_EN
    , .drop_cnt(w_drop_cnt)
`endif
  );
  typedef struct {
    logic [511:0] d;
    logic [63:0] k;
    logic [63:0] u;
    logic l;
  } beat_t;
  beat_t exp_q[$];
  beat_t mon_e;
  int n_cmp = 0, n_bad = 0, mode = 0, w_hs = 0, m_drops = 0;
  logic [31:0] m_exp[2], m_seq[2];
  logic m_val[2];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask
  task automatic model_reset();
    m_exp[0] = 1; m_exp[1] = 1;
    m_seq[0] = 0; m_seq[1] = 0;
    m_val[0] = 0; m_val[1] = 0;
    m_drops = 0;
  endtask
  task automatic chk_seq();
    chk("seq0_out", seq0_out, m_seq[0]);
    chk("seq0_valid", seq0_valid, m_val[0]);
    chk("seq1_out", seq1_out, m_seq[1]);
    chk("seq1_valid", seq1_valid, m_val[1]);
`ifdef ACK_SEQ_TRACKER_STATS_EN
    chk("drop_cnt", drop_cnt, m_drops);
`endif
  endtask
  always @(negedge clk) begin
    if (m_tvalid && m_tready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_beat: got m_tvalid=1 expected no beat");
      end else begin
        mon_e = exp_q.pop_front();
        if ({m_tdata, m_tkeep, m_tuser, m_tlast} !== {mon_e.d, mon_e.k, mon_e.u, mon_e.l}) begin
          n_bad++;
          $display("FAIL beat: got %h/%h last=%b expected %h/%h last=%b", m_tdata[127:0], m_tkeep,
                   m_tlast, mon_e.d[127:0], mon_e.k, mon_e.l);
        end
      end
    end
    if (w_m_tvalid && m_tready) w_hs++;
  end
  initial forever begin
    @(posedge clk);
    #1;
    m_tready = mode == 0 ? 1'b1 : (mode == 1 ? ~m_tready : 1'($urandom_range(0, 1)));
  end
  // rst_at >= 0 asserts reset while that beat is presented, abandoning the packet.
  task automatic send_pkt(input bit app, input logic [31:0] seq, input int nb, input int rst_at);
    logic [31:0] d;
    bit fwd, dup, hs;
    beat_t b;
    int waitc;
    d = m_exp[app] - seq;
    fwd = d == 0;
    dup = d != 0 && d <= 32'h8000_0000;
    for (int i = 0; i < nb; i++) begin
      for (int j = 0; j < 16; j++) b.d[j*32 +: 32] = $urandom;
      if (i == 0) begin
        b.d[31:0] = seq;
        b.d[32] = app;
      end
      b.k = {$urandom, $urandom};
      b.u = {$urandom, $urandom};
      b.l = i == nb - 1;
      s_tdata = b.d; s_tkeep = b.k; s_tuser = b.u; s_tlast = b.l; s_tvalid = 1;
      if (i == rst_at) begin
        reset = 1;
        #1;
        chk("rst_m_tvalid", m_tvalid, 0);
        chk("rst_s_tready", s_tready, 0);
        chk("rst_seq0_valid", seq0_valid, 0);
        chk("rst_seq1_valid", seq1_valid, 0);
        exp_q.delete();
        model_reset();
        s_tvalid = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 0;
        return;
      end
      if (fwd) exp_q.push_back(b);
      waitc = 0;
      do begin
        @(negedge clk);
        chk("s_tready", s_tready, fwd ? m_tready : 1'b1);
        hs = s_tready;
        @(posedge clk);
        #1;
        waitc++;
      end while (!hs && waitc < 50);
      if (!hs) begin
        n_cmp++;
        n_bad++;
        $display("FAIL handshake_timeout: got no s_tready expected handshake within 50 cycles");
      end
      if (i == 0) begin
        if (fwd) begin
          m_exp[app] = seq + 1;
          m_seq[app] = seq;
          m_val[app] = 1;
        end else if (!dup && m_drops != -1) m_drops++;
        chk_seq();
      end
    end
    s_tvalid = 0;
  endtask
  initial begin
    logic [31:0] sq;
    bit a;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_s_tready", s_tready, 0);
    chk("reset_m_tvalid", m_tvalid, 0);
    chk_seq();
    reset = 0;
    @(posedge clk);
    #1;
    send_pkt(0, 32'hFFFF_FFFF, 1, -1);
    chk("wrap_seq0_out_ff", w_seq0_out, 32'hFFFF_FFFF);
    chk("wrap_seq0_valid", w_seq0_valid, 1);
    send_pkt(0, 32'h0, 1, -1);
    chk("wrap_seq0_out_0", w_seq0_out, 0);
    chk("wrap_forwarded", w_hs, 2);
    send_pkt(0, 1, 3, -1);
    send_pkt(1, 1, 2, -1);
    send_pkt(1, 2, 1, -1);
    send_pkt(1, 2, 2, -1);
    send_pkt(0, 5, 2, -1);
    mode = 1;
    send_pkt(0, 2, 4, -1);
    mode = 0;
    send_pkt(0, m_exp[0], 4, 2);
    send_pkt(0, 1, 2, -1);
    for (int n = 0; n < 80; n++) begin
      mode = $urandom_range(0, 2);
      a = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 4))
        0, 1: sq = m_exp[a];
        2: sq = m_exp[a] - $urandom_range(1, 3);
        3: sq = m_exp[a] + $urandom_range(1, 3);
        default: sq = $urandom;
      endcase
      send_pkt(a, sq, $urandom_range(1, 4), -1);
    end
    repeat (3) @(posedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
